// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory request/response plus the decode-side queue output.
interface fetch_if;
  logic        mem_enable;
  logic [24:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_result;
  logic        redirect;
  logic [24:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [24:0] out_pc;

  modport master (
    output mem_enable, mem_addr, out_valid, out_instr, out_pc,
    input  mem_valid, mem_result, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  mem_enable, mem_addr, out_valid, out_instr, out_pc,
    output mem_valid, mem_result, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, prefetch queue toward decode,
// redirect flushes the queue and discards any response already in flight.
module fetch_unit #(
  parameter logic [24:0] RESET_PC = 25'h0000000,
  parameter int          QDEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_if.master                 bus,
  output logic                    dbg_state,
  output logic [$clog2(QDEPTH):0] dbg_count,
  output logic                    dbg_drop
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [24:0]   fetch_pc;
  logic [24:0]   addr_q;
  logic          drop;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   instr_q [QDEPTH];
  logic [24:0]   pc_q    [QDEPTH];

  logic          issue;
  logic          resp;
  logic          push;
  logic          pop;
  logic          has_space;
  logic [24:0]   redirect_aligned;

  assign has_space        = count < CW'(QDEPTH);
  assign redirect_aligned = bus.redirect_pc & ~25'h3;

  // Decode handshake: the head transfers on an edge where out_valid and out_ready are both
  // high; out_valid never depends on out_ready, and a redirect in that cycle wins over the pop.
  assign pop = (count != '0) && bus.out_ready && !bus.redirect;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    resp     = 1'b0;
    push     = 1'b0;
    unique case (state)
      IDLE: begin
        if (has_space && !bus.redirect) begin
          state_nx = WAIT;
          issue    = 1'b1;
        end
      end
      WAIT: begin
        if (bus.mem_valid) begin
          state_nx = IDLE;
          resp     = 1'b1;
          push     = !drop && !bus.redirect;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= RESET_PC;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      state <= state_nx;
      if (issue) begin
        addr_q <= fetch_pc;
      end
      if (bus.redirect) begin
        fetch_pc <= redirect_aligned;
      end else if (push) begin
        fetch_pc <= addr_q + 25'd4;
      end
      // Only one response can be in flight, so a single flag covers any number of redirects.
      if (resp) begin
        drop <= 1'b0;
      end else if (state == WAIT && bus.redirect) begin
        drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        instr_q[i] <= 32'h0;
        pc_q[i]    <= RESET_PC;
      end
    end else if (bus.redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= bus.mem_result;
        pc_q[wr_ptr]    <= addr_q;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.mem_enable = (state == WAIT);
  assign bus.mem_addr   = addr_q;
  assign bus.out_valid  = (count != '0);
  assign bus.out_instr  = instr_q[rd_ptr];
  assign bus.out_pc     = pc_q[rd_ptr];

  assign dbg_state = (state == WAIT);
  assign dbg_count = count;
  assign dbg_drop  = drop;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table, then multi-cycle sequences against an
// 8-cycle-latency memory model with a PC scoreboard, plus a wrap-around instance.
module tb_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_if bus2 ();

  logic       st1, drop1, st2, drop2;
  logic [2:0] cnt1, cnt2;

  fetch_unit #(.RESET_PC(25'h0000000), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dbg_state(st1), .dbg_count(cnt1), .dbg_drop(drop1)
  );

  fetch_unit #(.RESET_PC(25'h1FFFFFC), .QDEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus2),
    .dbg_state(st2), .dbg_count(cnt2), .dbg_drop(drop2)
  );

  // ---------------- memory model ----------------
  logic        model_en = 1'b0;
  logic        model_valid;
  logic [31:0] model_result;
  logic        model_busy;
  logic [3:0]  model_lat;
  logic        drv_valid = 1'b0;
  logic [31:0] drv_result = 32'h0;

  assign bus.mem_valid  = model_en ? model_valid  : drv_valid;
  assign bus.mem_result = model_en ? model_result : drv_result;

  always @(posedge clk) begin
    if (rst) begin
      model_valid  <= 1'b0;
      model_busy   <= 1'b0;
      model_lat    <= 4'd0;
      model_result <= 32'h0;
    end else if (model_valid) begin
      model_valid <= 1'b0;
    end else if (model_busy) begin
      if (model_lat == 4'd0) begin
        model_valid  <= 1'b1;
        model_result <= {7'b0, bus.mem_addr} ^ 32'hA5A5_0000;
        model_busy   <= 1'b0;
      end else begin
        model_lat <= model_lat - 4'd1;
      end
    end else if (bus.mem_enable) begin
      model_busy <= 1'b1;
      model_lat  <= 4'd7;
    end
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic        sb_en = 1'b0;
  logic [24:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // The accept decision is made with the inputs the coming edge will sample.
  task automatic tick();
    logic [24:0] e;
    logic [31:0] ei;
    if (sb_en && bus.out_valid && bus.out_ready && !bus.redirect) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got pc=%h instr=%h, required no word", bus.out_pc, bus.out_instr);
      end else begin
        e  = exp_q.pop_front();
        ei = {7'b0, e} ^ 32'hA5A5_0000;
        if (bus.out_pc !== e || bus.out_instr !== ei) begin
          bad++;
          $display("FAIL sb_word: got pc=%h instr=%h, required pc=%h instr=%h",
                   bus.out_pc, bus.out_instr, e, ei);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic ready);
    sb_en           = 1'b0;
    rst             = 1'b1;
    drv_valid       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 25'h0;
    bus.out_ready   = ready;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_enable_addr(input logic [24:0] addr, input int budget, input string name);
    for (int i = 0; i < budget && !(bus.mem_enable && bus.mem_addr == addr); i++) tick();
    check(name, {38'h0, bus.mem_enable, bus.mem_addr}, {38'h0, 1'b1, addr});
  endtask

  task automatic wait_sb_empty(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_redirect(input logic [24:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    tick();
    bus.redirect = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic        redir;
    logic [24:0] rpc;
    logic        ready;
    logic        e_en;
    logic [24:0] e_addr;
    logic        e_ov;
    logic [31:0] e_instr;
    logic [24:0] e_pc;
    logic [2:0]  e_cnt;
    logic        chk;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic v, logic [31:0] r, logic rd, logic [24:0] rp, logic rdy,
                              logic en, logic [24:0] a, logic ov, logic [31:0] ins,
                              logic [24:0] pc, logic [2:0] c, logic chk);
    vec_t t;
    t.valid = v;  t.result = r;   t.redir = rd;  t.rpc = rp;   t.ready = rdy;
    t.e_en = en;  t.e_addr = a;   t.e_ov = ov;   t.e_instr = ins;
    t.e_pc = pc;  t.e_cnt = c;    t.chk = chk;
    return t;
  endfunction

  int first_ov;

  initial begin
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 25'h0;
    bus.out_ready    = 1'b0;
    bus2.mem_valid   = 1'b0;
    bus2.mem_result  = 32'h0;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 25'h0;
    bus2.out_ready   = 1'b0;

    //      valid result        rd  rpc       rdy | en addr      ov instr         pc        cnt chk
    vq.push_back(mk(0, 32'h0,        0, 25'h0,   0,  1, 25'h000, 0, 32'h0,        25'h000, 0, 1));
    vq.push_back(mk(1, 32'h11111111, 0, 25'h0,   0,  0, 25'h000, 1, 32'h11111111, 25'h000, 1, 1));
    vq.push_back(mk(0, 32'h0,        0, 25'h0,   0,  1, 25'h004, 1, 32'h11111111, 25'h000, 1, 1));
    vq.push_back(mk(1, 32'h22222222, 0, 25'h0,   0,  0, 25'h004, 1, 32'h11111111, 25'h000, 2, 1));
    vq.push_back(mk(0, 32'h0,        0, 25'h0,   1,  1, 25'h008, 1, 32'h22222222, 25'h004, 1, 1));
    vq.push_back(mk(0, 32'h0,        1, 25'h103, 0,  1, 25'h008, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(1, 32'hDEADBEEF, 0, 25'h0,   0,  0, 25'h008, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(0, 32'h0,        0, 25'h0,   0,  1, 25'h100, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(1, 32'h33333333, 1, 25'h200, 0,  0, 25'h100, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(0, 32'h0,        0, 25'h0,   0,  1, 25'h200, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(1, 32'h44444444, 0, 25'h0,   0,  0, 25'h200, 1, 32'h44444444, 25'h200, 1, 1));
    vq.push_back(mk(0, 32'h0,        0, 25'h0,   0,  1, 25'h204, 1, 32'h44444444, 25'h200, 1, 1));
    vq.push_back(mk(1, 32'h55555555, 0, 25'h0,   1,  0, 25'h204, 1, 32'h55555555, 25'h204, 1, 1));
    vq.push_back(mk(0, 32'h0,        1, 25'h300, 1,  0, 25'h204, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(0, 32'h0,        0, 25'h0,   1,  1, 25'h300, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(0, 32'h0,        1, 25'h400, 0,  1, 25'h300, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(0, 32'h0,        1, 25'h501, 0,  1, 25'h300, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(1, 32'hCAFEF00D, 0, 25'h0,   0,  0, 25'h300, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(0, 32'h0,        0, 25'h0,   0,  1, 25'h500, 0, 32'h0,        25'h0,   0, 0));
    vq.push_back(mk(1, 32'h66666666, 0, 25'h0,   0,  0, 25'h500, 1, 32'h66666666, 25'h500, 1, 1));
    vq.push_back(mk(1, 32'hBADBAD00, 0, 25'h0,   0,  1, 25'h504, 1, 32'h66666666, 25'h500, 1, 1));
    vq.push_back(mk(1, 32'h77777777, 0, 25'h0,   0,  0, 25'h504, 1, 32'h66666666, 25'h500, 2, 1));
    vq.push_back(mk(0, 32'h0,        0, 25'h0,   1,  1, 25'h508, 1, 32'h77777777, 25'h504, 1, 1));
    vq.push_back(mk(0, 32'h0,        0, 25'h0,   1,  1, 25'h508, 0, 32'h0,        25'h0,   0, 0));

    // ---- reset state ----
    model_en = 1'b0;
    do_reset(1'b0);
    check("rst_en",    64'(bus.mem_enable), 64'd0);
    check("rst_addr",  64'(bus.mem_addr),   64'h0);
    check("rst_ov",    64'(bus.out_valid),  64'd0);
    check("rst_instr", 64'(bus.out_instr),  64'h0);
    check("rst_pc",    64'(bus.out_pc),     64'h0);
    check("rst_cnt",   64'(cnt1),           64'd0);
    check("rst_drop",  64'(drop1),          64'd0);
    check("rst_state", 64'(st1),            64'd0);
    check("rst_wrap_pc", 64'(bus2.out_pc),  64'h1FFFFFC);

    // ---- table-driven cycle vectors ----
    for (int i = 0; i < vq.size(); i++) begin
      drv_valid       = vq[i].valid;
      drv_result      = vq[i].result;
      bus.redirect    = vq[i].redir;
      bus.redirect_pc = vq[i].rpc;
      bus.out_ready   = vq[i].ready;
      tick();
      check($sformatf("vec%0d_en", i),   64'(bus.mem_enable), 64'(vq[i].e_en));
      check($sformatf("vec%0d_addr", i), 64'(bus.mem_addr),   64'(vq[i].e_addr));
      check($sformatf("vec%0d_ov", i),   64'(bus.out_valid),  64'(vq[i].e_ov));
      check($sformatf("vec%0d_cnt", i),  64'(cnt1),           64'(vq[i].e_cnt));
      if (vq[i].chk) begin
        check($sformatf("vec%0d_instr", i), 64'(bus.out_instr), 64'(vq[i].e_instr));
        check($sformatf("vec%0d_pc", i),    64'(bus.out_pc),    64'(vq[i].e_pc));
      end
    end
    drv_valid    = 1'b0;
    bus.redirect = 1'b0;

    // ---- RESET_PC at the top of the address space wraps to 0 ----
    do_reset(1'b0);
    tick();
    check("wrap_first_addr", {38'h0, bus2.mem_enable, bus2.mem_addr}, {38'h0, 1'b1, 25'h1FFFFFC});
    bus2.mem_valid  = 1'b1;
    bus2.mem_result = 32'h12345678;
    tick();
    bus2.mem_valid = 1'b0;
    check("wrap_ov",    64'(bus2.out_valid), 64'd1);
    check("wrap_pc",    64'(bus2.out_pc),    64'h1FFFFFC);
    check("wrap_instr", 64'(bus2.out_instr), 64'h12345678);
    tick();
    check("wrap_next_addr", {38'h0, bus2.mem_enable, bus2.mem_addr}, {38'h0, 1'b1, 25'h0});

    // ---- streaming with 8-cycle memory ----
    model_en = 1'b1;
    do_reset(1'b1);
    exp_q = '{25'h0, 25'h4, 25'h8, 25'hC};
    sb_en = 1'b1;
    first_ov = 0;
    for (int i = 1; i <= 30 && first_ov == 0; i++) begin
      tick();
      if (bus.out_valid) first_ov = i;
    end
    check("first_word_latency", 64'(first_ov), 64'd11);
    wait_sb_empty(80, "stream_done");
    sb_en = 1'b0;

    // ---- queue fills with decode stalled, then drains in order ----
    do_reset(1'b0);
    for (int i = 0; i < 100; i++) tick();
    check("full_cnt", 64'(cnt1),           64'd4);
    check("full_en",  64'(bus.mem_enable), 64'd0);
    check("full_ov",  64'(bus.out_valid),  64'd1);
    exp_q = '{25'h0, 25'h4, 25'h8, 25'hC};
    sb_en = 1'b1;
    bus.out_ready = 1'b1;
    wait_sb_empty(20, "full_drain");
    sb_en = 1'b0;
    wait_enable_addr(25'h10, 20, "full_resume_addr");

    // ---- redirect while the fetch of 0x8 is in flight ----
    do_reset(1'b1);
    exp_q = '{25'h0, 25'h4, 25'h100, 25'h104};
    sb_en = 1'b1;
    wait_enable_addr(25'h8, 40, "redir_wait_8");
    pulse_redirect(25'h103);
    check("redir_hold", {37'h0, bus.mem_enable, drop1, bus.mem_addr}, {37'h0, 1'b1, 1'b1, 25'h8});
    check("redir_flush_ov", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 20 && bus.mem_enable; i++) tick();
    check("redir_drop_cleared", {38'h0, bus.mem_enable, drop1}, 64'd0);
    tick();
    check("redir_new_addr", {38'h0, bus.mem_enable, bus.mem_addr}, {38'h0, 1'b1, 25'h100});
    wait_sb_empty(60, "redir_done");
    sb_en = 1'b0;

    // ---- redirect on the response cycle, then again mid-WAIT ----
    do_reset(1'b1);
    exp_q = '{25'h0, 25'h4, 25'h300, 25'h304};
    sb_en = 1'b1;
    wait_enable_addr(25'h8, 40, "same_wait_8");
    for (int i = 0; i < 20 && !model_valid; i++) tick();
    check("same_model_valid", 64'(model_valid), 64'd1);
    pulse_redirect(25'h200);
    check("same_after", {37'h0, bus.mem_enable, bus.out_valid, drop1}, 64'd0);
    tick();
    check("same_new_addr", {38'h0, bus.mem_enable, bus.mem_addr}, {38'h0, 1'b1, 25'h200});
    tick();
    pulse_redirect(25'h300);
    check("second_redir", {37'h0, bus.out_valid, drop1, bus.mem_addr}, {37'h0, 1'b0, 1'b1, 25'h200});
    wait_enable_addr(25'h300, 40, "second_redir_addr");
    wait_sb_empty(60, "same_done");
    sb_en = 1'b0;

    // ---- reset mid-WAIT with a stray response during reset ----
    do_reset(1'b1);
    exp_q = '{25'h0};
    sb_en = 1'b1;
    wait_enable_addr(25'h4, 40, "mid_wait_4");
    check("mid_sb_empty", 64'(exp_q.size()), 64'd0);
    sb_en = 1'b0;
    rst = 1'b1;
    model_en = 1'b0;
    tick();
    tick();
    drv_valid  = 1'b1;
    drv_result = 32'hBAD0BAD0;
    tick();
    drv_valid = 1'b0;
    tick();
    check("mid_rst_state", {36'h0, bus.mem_enable, bus.out_valid, cnt1, drop1, bus.mem_addr},
          {36'h0, 1'b0, 1'b0, 3'd0, 1'b0, 25'h0});
    rst = 1'b0;
    model_en = 1'b1;
    exp_q = '{25'h0, 25'h4};
    sb_en = 1'b1;
    tick();
    check("mid_restart_addr", {38'h0, bus.mem_enable, bus.mem_addr}, {38'h0, 1'b1, 25'h0});
    wait_sb_empty(60, "mid_done");
    sb_en = 1'b0;

    // ---- report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
